fpmul_seq_core: RTL and testbench
=================================

# fpmul_seq_core

Sequential IEEE-754 single-precision multiply core. Consumes two operands from the upstream 32-bit operand registers, produces a packed 32-bit product with status flags, and hands the result to the downstream result register. Mantissas are multiplied by a shift-add datapath over several cycles. Valid/ready handshakes on both sides.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per MUL cycle; legal values are 1, 2, 4, 8 (divides 24).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: core can accept operands; high only in IDLE.
- `a` in 32: operand A, IEEE-754 single.
- `b` in 32: operand B, IEEE-754 single.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: downstream accepts result.
- `result` out 32: packed product.
- `out_flags` out 3: [2] invalid, [1] overflow, [0] underflow; meaningful only while `out_valid` is high.

## Operation
- FSM states and transitions:
  - IDLE → MUL on `in_valid && in_ready`; `a` and `b` are captured on that edge.
  - MUL → NORM after N = 24/`BITS_PER_CYCLE` cycles.
  - NORM → DONE after 1 cycle.
  - DONE → IDLE on `out_valid && out_ready`.
- Unpack:
  - sign = a[31]^b[31].
  - Exponents are 8-bit; mantissas are 24-bit with the hidden bit.
  - Denormal inputs (exp==0) are flushed to signed zero.
- Exponent: 10-bit signed e = ea + eb − 127, computed at capture.
- MUL: 48-bit accumulator. Each cycle adds `BITS_PER_CYCLE` partial products from the LSBs of B and shifts.
- NORM:
  - If prod[47]=1: mant = prod[46:24], e+1, guard = prod[23], sticky = |prod[22:0].
  - Else: mant = prod[45:23], guard = prod[22], sticky = |prod[21:0].
  - Rounding is per Configuration. A mantissa carry-out renormalises and increments e.
- Range:
  - e ≥ 255: result ±inf (0x7F800000 | sign), overflow flag set.
  - e ≤ 0: result ±0, underflow flag set. No denormal outputs.
- Specials are resolved at capture but still take full latency; the datapath result is discarded.
  - Either input NaN, or inf×0: result 0x7FC00000, invalid flag set.
  - inf × nonzero finite/inf: result signed inf, no flags.
  - Zero × finite: signed zero, no flags.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `out_flags`=0, accumulator=0.
- `result` and `out_flags` are registered and stable throughout DONE.

## Timing
- Acceptance edge t0. `out_valid` first high after edge t0+N+1. For `BITS_PER_CYCLE`=1, that is 25 cycles.
- `in_ready` is decoded from state: low from t0+1 until the cycle after the output handshake.
- DONE with `out_ready`=1 and `in_valid`=1 in the same cycle: no input is accepted. The FSM returns to IDLE and accepts no earlier than the next edge, giving one bubble cycle minimum between results.
- `out_ready` low in DONE: result and flags hold indefinitely, with no change.
- `in_valid` and operands are ignored outside IDLE.
- Reset asserted mid-operation: abort immediately, all outputs return to reset values, and the in-flight result is lost. Resume in IDLE on the first edge after deassertion.
- Throughput: one result per N+3 cycles at best.

## Configuration
- `FPMUL_RNE_EN` defined: round-to-nearest-even. Increment mant when guard && (sticky || mant[0]).
- `FPMUL_RNE_EN` undefined: truncate toward zero. Guard and sticky are ignored.
- Latency is identical in both builds.

## Test plan
- Basic multiply: a=0x40000000, b=0x40400000 (2.0×3.0) → result 0x40C00000, flags 000, `out_valid` exactly 25 cycles after accept (`BITS_PER_CYCLE`=1).
- Normalise carry: a=b=0x3FC00000 (1.5×1.5) → 0x40100000. Then a=0x3F800001, b=0x3FC00000 → 0x3FC00002 with `FPMUL_RNE_EN`, 0x3FC00001 without.
- Range: a=b=0x7F000000 → 0x7F800000, flags 010. a=b=0x00800000 → 0x00000000, flags 001. a=0x80800000, b=0x00800000 → 0x80000000, flags 001.
- Specials: 0x7F800000×0x00000000 → 0x7FC00000, flags 100. 0xFF800000×0x40000000 → 0xFF800000, flags 000. 0x7FC00001×1.0 → 0x7FC00000, flags 100.
- Handshake: hold `out_ready`=0 for 10 cycles in DONE → result stable, `in_ready`=0. Pulse `in_valid` with `out_ready` → no accept that cycle, accept on the following edge.
- Reset: assert reset at cycle 10 of a 2.0×3.0 operation → `out_valid`=0, `in_ready`=1 while asserted. After release, 1.5×1.5 completes to 0x40100000 with correct latency.

Source files
------------

// File: rtl/fpmul_seq_core.sv
// Sequential IEEE-754 single-precision multiplier: capture, shift-add MUL, NORM, DONE.
// Optional build macro FPMUL_RNE_EN selects round-to-nearest-even; otherwise truncation.
module fpmul_seq_core #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  out_flags,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Operands transfer only in IDLE; the result is offered in DONE and held until taken.

  localparam int         N    = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [47:0]        mcand_q, mcand_d;
  logic [23:0]        mplier_q, mplier_d;
  logic [47:0]        acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               special_q, special_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic [2:0]         spec_flags_q, spec_flags_d;
  logic [31:0]        result_q, result_d;
  logic [2:0]         flags_q, flags_d;

  // Operand unpack and special-case classification at capture time.
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        cap_sign;
  logic signed [9:0] cap_exp;
  logic        cap_special;
  logic [31:0] cap_res;
  logic [2:0]  cap_flags;

  always_comb begin
    ea       = a[30:23];
    eb       = b[30:23];
    fa       = a[22:0];
    fb       = b[22:0];
    a_nan    = (&ea) && (|fa);
    b_nan    = (&eb) && (|fb);
    a_inf    = (&ea) && !(|fa);
    b_inf    = (&eb) && !(|fb);
    a_zero   = !(|ea);
    b_zero   = !(|eb);
    cap_sign = a[31] ^ b[31];
    cap_exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    cap_special = 1'b1;
    cap_res     = 32'd0;
    cap_flags   = 3'b000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      cap_res   = 32'h7FC0_0000;
      cap_flags = 3'b100;
    end else if (a_inf || b_inf) begin
      cap_res = {cap_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      cap_res = {cap_sign, 31'd0};
    end else begin
      cap_special = 1'b0;
    end
  end

  // Partial products for the multiplier bits retired this cycle.
  logic [47:0] pp_sum;
  always_comb begin
    pp_sum = 48'd0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) pp_sum = pp_sum + (mcand_q << j);
    end
  end

  // Normalise, round and range-check the accumulated product.
  logic [22:0]       mant_n;
  logic              guard, sticky, round_inc;
  logic signed [9:0] exp_n, exp_r;
  logic [23:0]       mant_sum;
  logic [31:0]       norm_res;
  logic [2:0]        norm_flags;

  always_comb begin
    if (acc_q[47]) begin
      mant_n = acc_q[46:24];
      guard  = acc_q[23];
      sticky = |acc_q[22:0];
      exp_n  = exp_q + 10'sd1;
    end else begin
      mant_n = acc_q[45:23];
      guard  = acc_q[22];
      sticky = |acc_q[21:0];
      exp_n  = exp_q;
    end
`ifdef FPMUL_RNE_EN
    round_inc = guard && (sticky || mant_n[0]);
`else
    round_inc = 1'b0;
`endif
    mant_sum = {1'b0, mant_n} + {23'd0, round_inc};
    exp_r    = mant_sum[23] ? (exp_n + 10'sd1) : exp_n;

    if (exp_r >= 10'sd255) begin
      norm_res   = {sign_q, 8'hFF, 23'd0};
      norm_flags = 3'b010;
    end else if (exp_r <= 10'sd0) begin
      norm_res   = {sign_q, 31'd0};
      norm_flags = 3'b001;
    end else begin
      norm_res   = {sign_q, exp_r[7:0], mant_sum[22:0]};
      norm_flags = 3'b000;
    end
  end

`ifndef FPMUL_RNE_EN
  logic round_unused;
  assign round_unused = guard ^ sticky;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    special_d    = special_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    result_d     = result_q;
    flags_d      = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d       = cap_sign;
          exp_d        = cap_exp;
          mcand_d      = {24'd0, 1'b1, fa};
          mplier_d     = {1'b1, fb};
          acc_d        = 48'd0;
          cnt_d        = 5'd0;
          special_d    = cap_special;
          spec_res_d   = cap_res;
          spec_flags_d = cap_flags;
          state_d      = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = acc_q + pp_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST) state_d = S_NORM;
      end
      S_NORM: begin
        result_d = special_q ? spec_res_q : norm_res;
        flags_d  = special_q ? spec_flags_q : norm_flags;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sign_q       <= 1'b0;
      exp_q        <= 10'sd0;
      mcand_q      <= 48'd0;
      mplier_q     <= 24'd0;
      acc_q        <= 48'd0;
      cnt_q        <= 5'd0;
      special_q    <= 1'b0;
      spec_res_q   <= 32'd0;
      spec_flags_q <= 3'b000;
      result_q     <= 32'd0;
      flags_q      <= 3'b000;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      special_q    <= special_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign out_flags   = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpmul_seq_core.sv
// Self-checking bench for fpmul_seq_core: directed plan vectors plus random operands
// against a value-level float multiply model.
module tb_fpmul_seq_core;

  localparam int BPC = 1;
  localparam int N   = 24 / BPC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic [2:0]  out_flags;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] exp_q[$];

  fpmul_seq_core #(.BITS_PER_CYCLE(BPC)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_flags  (out_flags),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Exact product of the two significands, scaled back to 24 bits by value.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    int unsigned ex, ey;
    logic        s, xnan, ynan, xinf, yinf, xz, yz;
    logic [63:0] p, kept, rem, half;
    int          sh, e;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xnan = (ex == 255) && (x[22:0] != 0);
    ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0);
    yinf = (ey == 255) && (y[22:0] == 0);
    xz   = (ex == 0);
    yz   = (ey == 0);
    if (xnan || ynan || (xinf && yz) || (yinf && xz)) return {3'b100, 32'h7FC0_0000};
    if (xinf || yinf) return {3'b000, s, 8'hFF, 23'd0};
    if (xz || yz) return {3'b000, s, 31'd0};
    p  = (64'd1 << 23 | 64'(x[22:0])) * (64'd1 << 23 | 64'(y[22:0]));
    sh = 0;
    while ((p >> (24 + sh)) != 0) sh++;
    kept = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    e    = int'(ex) + int'(ey) - 150 + sh;
`ifdef FPMUL_RNE_EN
    if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
`else
    if (rem > half) kept = kept;
`endif
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b001, s, 31'd0};
    return {3'b000, s, 8'(e), kept[22:0]};
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    check_eq("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result();
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check_eq("latency", 32'(k), 32'(N + 1));
  endtask

  task automatic finish_op(input int hold, input bit bubble, input logic [31:0] nx,
                           input logic [31:0] ny);
    logic [34:0] e;
    e = 35'd0;
    if (exp_q.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
    else e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_result", result, e[31:0]);
      check_eq("hold_flags", 32'(out_flags), 32'(e[34:32]));
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    check_eq("result", result, e[31:0]);
    check_eq("flags", 32'(out_flags), 32'(e[34:32]));
    out_ready = 1'b1;
    if (bubble) begin
      a = nx;
      b = ny;
      in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_valid", 32'(out_valid), 32'd0);
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    if (bubble) begin
      exp_q.push_back(model(nx, ny));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("bubble_accept", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int hold);
    issue(x, y);
    wait_result();
    finish_op(hold, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    int unsigned c;
    c = $urandom_range(0, 99);
    if (c < 60) return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
    if (c < 75) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    if (c < 85) return {1'($urandom), 8'd0, 23'($urandom_range(0, 1) ? $urandom : 0)};
    if (c < 92) return {1'($urandom), 8'hFF, 23'd0};
    return {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
  endfunction

  logic [31:0] dir_a[9] = '{32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h7F00_0000,
                            32'h0080_0000, 32'h8080_0000, 32'h7F80_0000, 32'hFF80_0000,
                            32'h7FC0_0001};
  logic [31:0] dir_b[9] = '{32'h4040_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32'h7F00_0000,
                            32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 32'h4000_0000,
                            32'h3F80_0000};

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_flags", 32'(out_flags), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) do_op(dir_a[i], dir_b[i], 0);

    // Back-pressure for 10 cycles, then a same-cycle input request that must bubble.
    issue(32'h4000_0000, 32'h4040_0000);
    wait_result();
    finish_op(10, 1'b1, 32'h3FC0_0000, 32'h3FC0_0000);
    wait_result();
    finish_op(0, 1'b0, 32'd0, 32'd0);

    // Abort mid-operation.
    issue(32'h4000_0000, 32'h4040_0000);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_result", result, 32'd0);
    check_eq("abort_flags", 32'(out_flags), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    check_eq("abort_hold_valid", 32'(out_valid), 32'd0);
    check_eq("abort_hold_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    do_op(32'h3FC0_0000, 32'h3FC0_0000, 0);

    for (int i = 0; i < 40; i++) do_op(rand_operand(), rand_operand(), $urandom_range(0, 3));

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
